regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file between up to N_REQ writeback sources: 0 = ALU writeback, 1 = load return, 2 = debug/CSR injection.
- Uses round-robin arbitration with a registered write stage.
- Holds a per-register pending-load scoreboard and raises read-hazard flags for the decode stage.
- Sits between the writeback sources and the register file's wr_en/wr_addr/wr_data inputs.

Parameters:
- WIDTH_ADDR, 5, register address width; the file has 2**WIDTH_ADDR entries.
- WIDTH_DATA, 32, register data width.
- N_REQ, 3, number of write requesters (2..8).
- LOAD_REQ, 1, index of the requester whose commits clear scoreboard bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*WIDTH_ADDR  packed destination addresses; requester i occupies bits [i*WIDTH_ADDR +: WIDTH_ADDR].
- req_data  in  N_REQ*WIDTH_DATA  packed write data, same packing.
- req_ready  out  N_REQ  one-hot grant; the request is accepted when valid&ready.
- pend_set  in  1  a load issued this cycle; marks pend_addr busy.
- pend_addr  in  WIDTH_ADDR  destination of the issued load.
- rd_addr1  in  WIDTH_ADDR  decode read address, port 1.
- rd_addr2  in  WIDTH_ADDR  decode read address, port 2.
- hazard1  out  1  rd_addr1 is not yet readable.
- hazard2  out  1  rd_addr2 is not yet readable.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  WIDTH_ADDR  register file write address (registered).
- wr_data  out  WIDTH_DATA  register file write data (registered).
- busy_vec  out  2**WIDTH_ADDR  scoreboard state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, busy_vec=0, rr_ptr=0.
  - Combinational outputs with all inputs low: req_ready=0, hazard1=0, hazard2=0.
  - A load pending when reset asserts is discarded, and so is a staged write.
- Arbitration (combinational, same cycle):
  - Search starts at rr_ptr and moves upward modulo N_REQ; the first requester with req_valid set is granted.
  - req_ready is one-hot or zero and never depends on req_ready.
  - At most one acceptance per cycle; the arbiter never stalls, because the register file accepts a write every cycle.
- Pointer update: on acceptance by requester g, rr_ptr <= (g+1) mod N_REQ. With no acceptance, rr_ptr holds.
- Write stage (1-cycle latency): the request accepted in cycle N drives wr_addr/wr_data in cycle N+1.
  - wr_en=1 in cycle N+1 only if the accepted address is nonzero.
  - A write to x0 is still accepted and still advances rr_ptr, but produces wr_en=0.
  - With no acceptance in cycle N, wr_en=0 in cycle N+1; wr_addr/wr_data hold their last values.
- Scoreboard (one busy bit per register):
  - Set: pend_set with pend_addr!=0 sets busy[pend_addr]. pend_set to x0 is ignored.
  - Clear: acceptance from requester LOAD_REQ clears busy[its addr] at the same clock edge.
  - Same edge, same address, set and clear: set wins (a new load is outstanding).
  - Same edge, different addresses: both take effect.
  - busy[0] is constant 0.
- Hazards (combinational):
  - hazardK = busy[rd_addrK] OR (wr_en AND wr_addr==rd_addrK), K = 1 or 2.
  - The second term covers the staged write that is not yet in the register file.
  - rd_addrK==0 never produces a hazard.
- Non-load requesters writing a busy register are accepted normally and do not clear the bit (write-after-write ordering is the issuer's responsibility).

Decomposition:
- Shared package (regfile_pkg): WIDTH_ADDR, WIDTH_DATA, N_REQ, requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; outputs one-hot gnt and encoded gnt_idx) is natural and reusable.
- The scoreboard and write stage stay inline.

Test Plan:
- Reset mid-operation: set busy[5] via a load, stage a write to x7, then assert rst_n=0 asynchronously between clock edges. Required: wr_en=0, busy_vec=0, hazard1=0 immediately, and rr_ptr=0 afterwards.
- Round-robin fairness: all three requesters valid every cycle with addrs 1/2/3. Required: grants 0,1,2,0,1,2 and wr_addr sequence 1,2,3,1,2,3 starting one cycle after the first grant.
- Load hazard: pend_set addr 9, next cycle rd_addr1=9. Required: hazard1=1 until requester 1 writes addr 9 with data 0xDEADBEEF. Then busy[9] clears at that edge, hazard1 stays 1 for one more cycle (wr_addr=9), then goes 0 with 0xDEADBEEF in the register file.
- Set/clear collision: pend_set addr 4 in the same cycle requester 1 is accepted with addr 4. Required: busy[4]=1 afterwards.
- x0 handling: requester 2 writes addr 0 data 0x1234; pend_set addr 0; rd_addr2=0. Required: req_ready[2]=1, wr_en=0 the next cycle, busy_vec unchanged, hazard2=0.
- Sparse requests: only requester 2 valid, then only requester 0. Required: immediate grant each time, rr_ptr goes 0→0→1, and wr_en=0 on cycles with no acceptance.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter slice.
// Widths, requester count and requester index assignments.
package regfile_pkg;

    localparam int WIDTH_ADDR = 5;
    localparam int WIDTH_DATA = 32;
    localparam int N_REQ      = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, wraps mod N.
// Ports: req (N requests), ptr (start index) -> gnt (one-hot), gnt_idx.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic found;
    int   j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between N_REQ writeback sources,
// stages the winning write one cycle and tracks pending-load hazards.
// Ports: req_valid/req_addr/req_data -> req_ready (one-hot grant);
// pend_set/pend_addr mark a load outstanding; rd_addr1/2 -> hazard1/2;
// wr_en/wr_addr/wr_data drive the register file; busy_vec is debug.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH_ADDR = regfile_pkg::WIDTH_ADDR,
    parameter int WIDTH_DATA = regfile_pkg::WIDTH_DATA,
    parameter int N_REQ      = regfile_pkg::N_REQ,
    parameter int LOAD_REQ   = REQ_LOAD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*WIDTH_ADDR-1:0]   req_addr,
    input  logic [N_REQ*WIDTH_DATA-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          pend_set,
    input  logic [WIDTH_ADDR-1:0]         pend_addr,
    input  logic [WIDTH_ADDR-1:0]         rd_addr1,
    input  logic [WIDTH_ADDR-1:0]         rd_addr2,
    output logic                          hazard1,
    output logic                          hazard2,
    output logic                          wr_en,
    output logic [WIDTH_ADDR-1:0]         wr_addr,
    output logic [WIDTH_DATA-1:0]         wr_data,
    output logic [(1<<WIDTH_ADDR)-1:0]    busy_vec
);

    localparam int NREG = 1 << WIDTH_ADDR;
    localparam int PW   = $clog2(N_REQ);

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         rr_ptr_n;
    logic [N_REQ-1:0]      gnt;
    logic [PW-1:0]         gnt_idx;
    logic                  accept;
    logic [WIDTH_ADDR-1:0] sel_addr;
    logic [WIDTH_DATA-1:0] sel_data;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_n;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign sel_addr  = req_addr[int'(gnt_idx)*WIDTH_ADDR +: WIDTH_ADDR];
    assign sel_data  = req_data[int'(gnt_idx)*WIDTH_DATA +: WIDTH_DATA];

    always_comb begin
        rr_ptr_n = rr_ptr;
        if (accept) begin
            rr_ptr_n = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_n;
        end
    end

    // Address/data hold when idle; only the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (accept) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Clear first, then set, so a new load to the same register wins.
    always_comb begin
        busy_n = busy;
        if (accept && int'(gnt_idx) == LOAD_REQ) begin
            busy_n[sel_addr] = 1'b0;
        end
        if (pend_set) begin
            busy_n[pend_addr] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_n;
        end
    end

    assign busy_vec = busy;

    // The staged write is not in the register file until the next edge.
    assign hazard1 = (rd_addr1 != '0) &&
                     (busy[rd_addr1] || (wr_en && wr_addr == rd_addr1));
    assign hazard2 = (rd_addr2 != '0) &&
                     (busy[rd_addr2] || (wr_en && wr_addr == rd_addr2));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter with a
// behavioural model of grants, staged writes and the load scoreboard.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [4:0]  aa [3];
    logic [31:0] dd [3];
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy_vec;

    assign req_addr = {aa[2], aa[1], aa[0]};
    assign req_data = {dd[2], dd[1], dd[0]};

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_vec  (busy_vec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    bit          mbusy [32];
    int          mptr;
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mbusy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic bit mhaz(input logic [4:0] a);
        if (a == 0) return 1'b0;
        return mbusy[a] || (m_en && m_addr == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        mptr   = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
        for (int i = 0; i < 3; i++) begin
            aa[i] = '0;
            dd[i] = '0;
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic step(input string tag);
        int g;
        g = -1;
        #1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (mptr + k) % 3;
            if (g < 0 && req_valid[i]) g = i;
        end
        chk({tag, ".ready"}, 64'(req_ready),
            (g >= 0) ? 64'(3'b001 << g) : 64'd0);
        chk({tag, ".hz1"}, 64'(hazard1), 64'(mhaz(rd_addr1)));
        chk({tag, ".hz2"}, 64'(hazard2), 64'(mhaz(rd_addr2)));
        @(posedge clk);
        if (g >= 0) begin
            m_en   = (aa[g] != 0);
            m_addr = aa[g];
            m_data = dd[g];
            mptr   = (g + 1) % 3;
            if (g == 1) mbusy[aa[g]] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (pend_set && pend_addr != 0) mbusy[pend_addr] = 1'b1;
        #1;
        chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_en));
        chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_addr));
        chk({tag, ".wr_data"}, 64'(wr_data), 64'(m_data));
        chk({tag, ".busy"}, 64'(busy_vec), 64'(mbusy_vec()));
        chk({tag, ".ptr"}, 64'(dut.rr_ptr), 64'(mptr));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst.ready", 64'(req_ready), 64'd0);
        chk("rst.hz1", 64'(hazard1), 64'd0);
        chk("rst.hz2", 64'(hazard2), 64'd0);
        chk("rst.wr_en", 64'(wr_en), 64'd0);
        chk("rst.busy", 64'(busy_vec), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sparse requests: pointer 0 -> 0 -> 1, idle cycles drop wr_en.
        req_valid = 3'b100; aa[2] = 5'd6; dd[2] = 32'h66;
        step("sparse2");
        idle_inputs();
        step("sparse_idle");
        req_valid = 3'b001; aa[0] = 5'd8; dd[0] = 32'h88;
        step("sparse0");
        idle_inputs();
        step("sparse_idle2");

        // Round-robin fairness from pointer 1: 1,2,0,1,2,0.
        for (int c = 0; c < 6; c++) begin
            req_valid = 3'b111;
            for (int i = 0; i < 3; i++) begin
                aa[i] = 5'(i + 1);
                dd[i] = 32'(100 + c * 3 + i);
            end
            step("rr");
        end
        idle_inputs();

        // Load hazard on x9.
        pend_set = 1'b1; pend_addr = 5'd9;
        step("ld_issue");
        pend_set = 1'b0;
        rd_addr1 = 5'd9;
        step("ld_wait");
        step("ld_wait2");
        req_valid = 3'b010; aa[1] = 5'd9; dd[1] = 32'hDEADBEEF;
        step("ld_ret");
        req_valid = '0;
        step("ld_staged");
        step("ld_done");
        idle_inputs();

        // Set/clear collision on x4.
        pend_set = 1'b1; pend_addr = 5'd4;
        step("coll_pre");
        req_valid = 3'b010; aa[1] = 5'd4; dd[1] = 32'h44;
        pend_set = 1'b1; pend_addr = 5'd4;
        rd_addr2 = 5'd4;
        step("coll");
        idle_inputs();

        // x0 handling.
        req_valid = 3'b100; aa[2] = 5'd0; dd[2] = 32'h1234;
        pend_set = 1'b1; pend_addr = 5'd0;
        step("x0");
        idle_inputs();
        rd_addr2 = 5'd0;
        step("x0_after");

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                aa[i] = 5'($urandom_range(0, 15));
                dd[i] = $urandom;
            end
            pend_set  = ($urandom_range(0, 3) == 0);
            pend_addr = 5'($urandom_range(0, 15));
            rd_addr1  = 5'($urandom_range(0, 15));
            rd_addr2  = 5'($urandom_range(0, 15));
            step("rand");
        end
        idle_inputs();

        // Asynchronous reset between edges with a load and write in flight.
        req_valid = 3'b001; aa[0] = 5'd7; dd[0] = 32'h77;
        pend_set = 1'b1; pend_addr = 5'd5;
        step("arst_pre");
        idle_inputs();
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.wr_en", 64'(wr_en), 64'd0);
        chk("arst.busy", 64'(busy_vec), 64'd0);
        chk("arst.hz1", 64'(hazard1), 64'd0);
        chk("arst.hz2", 64'(hazard2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst.ptr", 64'(dut.rr_ptr), 64'd0);
        req_valid = 3'b110; aa[1] = 5'd3; aa[2] = 5'd2;
        dd[1] = 32'h31; dd[2] = 32'h21;
        step("arst_post");
        idle_inputs();
        step("arst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
